// File: rtl/arithmetic_left_shift_saturating_pipelined_pkg.sv
// -----------------------------------------------------------------------------
// arithmetic_left_shift_saturating_pipelined_pkg
//
// Purpose:
//   Shared constants and helpers for the saturating arithmetic-left-shift
//   pipeline. The saturation helpers return the extreme values of an n-bit
//   two's-complement number, right-aligned in a MAX_N-bit vector, so each
//   user slices off the width it needs.
//
// Contents:
//   MAX_N          widest data width the helpers support
//   sat_max(n)     0 followed by n-1 ones  (most positive n-bit value)
//   sat_min(n)     1 followed by n-1 zeros (most negative n-bit value)
// -----------------------------------------------------------------------------
package arithmetic_left_shift_saturating_pipelined_pkg;

    localparam int MAX_N = 64;

    // Most positive n-bit two's-complement value: bits [n-2:0] set.
    function automatic logic [MAX_N-1:0] sat_max(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative n-bit two's-complement value: only bit [n-1] set.
    function automatic logic [MAX_N-1:0] sat_min(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arithmetic_left_shift_saturating_pipelined_if.sv
// -----------------------------------------------------------------------------
// arithmetic_left_shift_saturating_pipelined_if
//
// Purpose:
//   Bundles the input (sample) and output (result) handshakes of the
//   saturating arithmetic-left-shift pipeline.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   1. The sender keeps valid and its payload stable until that transfer;
//   ready may change freely and never depends on valid of the same channel
//   in a way that could form a loop. The pipeline holds out_data/out_ovf
//   stable while out_valid is 1 and out_ready is 0.
//
// Signals:
//   in_valid   producer -> block  input sample present
//   in_ready   block -> producer  block accepts the input this cycle
//   in_data    producer -> block  N-bit signed operand
//   in_shamt   producer -> block  left-shift amount, 0..N-1
//   out_valid  block -> consumer  result present
//   out_ready  consumer -> block  consumer accepts the result this cycle
//   out_data   block -> consumer  N-bit signed saturated result
//   out_ovf    block -> consumer  saturation occurred for this result
//
// Modports:
//   slave   the shift pipeline itself
//   master  the surrounding producer/consumer pair
// -----------------------------------------------------------------------------
interface arithmetic_left_shift_saturating_pipelined_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    import arithmetic_left_shift_saturating_pipelined_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_ovf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_shamt,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ovf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_shamt,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ovf
    );

endinterface

// File: rtl/arithmetic_left_shift_saturating_pipelined_stage.sv
// -----------------------------------------------------------------------------
// arithmetic_left_shift_stage
//
// Purpose:
//   One stage of the log-shifter. When bit K of the carried shift amount is
//   set, the data is shifted left by 2^K; otherwise it passes unchanged.
//   Overflow is detected from the bits that fall off the top plus the new
//   sign bit, and is OR-ed into the sticky flag from earlier stages. The
//   last stage (K == SW-1) replaces the data with the saturation value of
//   the original sign whenever the sticky flag is set, before its register.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             load enable (global pipeline advance)
//   src_*          fields arriving from the previous stage / block input
//   dst_*          registered fields presented to the next stage / output
//     valid        sample present
//     ovf          sticky overflow
//     sign         sign of the original operand
//     shamt        full shift amount, carried for later stages
//     data         partially shifted (or, last stage, saturated) data
// -----------------------------------------------------------------------------
module arithmetic_left_shift_stage #(
    parameter int N  = 8,
    parameter int SW = 3,
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          src_valid,
    input  logic          src_ovf,
    input  logic          src_sign,
    input  logic [SW-1:0] src_shamt,
    input  logic [N-1:0]  src_data,
    output logic          dst_valid,
    output logic          dst_ovf,
    output logic          dst_sign,
    output logic [SW-1:0] dst_shamt,
    output logic [N-1:0]  dst_data
);
    import arithmetic_left_shift_saturating_pipelined_pkg::*;

    // Shift distance of this stage.
    localparam int S = 1 << K;
    localparam bit LAST = (K == SW - 1);

    localparam logic [MAX_N-1:0] SAT_MAX_W = sat_max(N);
    localparam logic [MAX_N-1:0] SAT_MIN_W = sat_min(N);
    localparam logic [N-1:0]     SAT_MAX   = SAT_MAX_W[N-1:0];
    localparam logic [N-1:0]     SAT_MIN   = SAT_MIN_W[N-1:0];

    logic [S:0]   top_bits;
    logic         hit_ovf;
    logic         nxt_ovf;
    logic [N-1:0] shifted;
    logic [N-1:0] nxt_data;

    // Shifting left by S is exact only when the S bits that leave the word
    // and the bit that becomes the new sign all equal the current sign.
    assign top_bits = src_data[N-1 -: S+1];
    assign hit_ovf  = src_shamt[K] && !((top_bits == '0) || (top_bits == '1));
    assign nxt_ovf  = src_ovf | hit_ovf;

    always_comb begin
        shifted = src_data;
        if (src_shamt[K]) begin
            shifted = {src_data[N-1-S:0], {S{1'b0}}};
        end
    end

    // Data after an overflow is meaningless, so only the last stage needs to
    // replace it; earlier stages keep shifting whatever they hold.
    always_comb begin
        nxt_data = shifted;
        if (LAST && nxt_ovf) begin
            nxt_data = src_sign ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid <= 1'b0;
            dst_ovf   <= 1'b0;
            dst_sign  <= 1'b0;
            dst_shamt <= '0;
            dst_data  <= '0;
        end else if (en) begin
            dst_valid <= src_valid;
            dst_ovf   <= nxt_ovf;
            dst_sign  <= src_sign;
            dst_shamt <= src_shamt;
            dst_data  <= nxt_data;
        end
    end

endmodule

// File: rtl/arithmetic_left_shift_saturating_pipelined.sv
// -----------------------------------------------------------------------------
// arithmetic_left_shift_saturating_pipelined
//
// Purpose:
//   Signed multiply of an N-bit two's-complement sample by 2^shamt, built as
//   a registered log-shifter of SW = log2(N) stages. Stage k shifts by 2^k
//   when shamt bit k is set. The result saturates to the signed range and
//   out_ovf reports when that happened. Latency is SW cycles, throughput one
//   sample per cycle.
//
//   The whole pipeline advances as one unit: it moves whenever the output
//   register is empty or being drained. A stall at the output therefore
//   freezes every stage, which keeps the held output stable and guarantees
//   that no sample is lost or duplicated.
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset; drops all in-flight samples
//   bus     slave side of arithmetic_left_shift_saturating_pipelined_if
//           (in_valid/in_ready/in_data/in_shamt,
//            out_valid/out_ready/out_data/out_ovf)
//
// Parameters:
//   N       data width, power of two, N >= 4 (must match the interface)
// -----------------------------------------------------------------------------
module arithmetic_left_shift_saturating_pipelined #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    arithmetic_left_shift_saturating_pipelined_if.slave bus
);
    import arithmetic_left_shift_saturating_pipelined_pkg::*;

    localparam int SW = $clog2(N);

    // Fields carried from stage to stage. Entry 0 is the block input,
    // entry k+1 is the register of stage k, entry SW is the output register.
    typedef struct packed {
        logic          valid;
        logic          ovf;
        logic          orig_sign;
        logic [SW-1:0] shamt;
        logic [N-1:0]  data;
    } stage_t;

    stage_t pipe [SW+1];
    logic   advance;

    // Output register empty, or its content leaves this cycle.
    assign advance      = !pipe[SW].valid || bus.out_ready;
    assign bus.in_ready = advance;

    // A bubble (in_valid = 0) simply enters as an invalid entry.
    assign pipe[0].valid     = bus.in_valid;
    assign pipe[0].ovf       = 1'b0;
    assign pipe[0].orig_sign = bus.in_data[N-1];
    assign pipe[0].shamt     = bus.in_shamt;
    assign pipe[0].data      = bus.in_data;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        arithmetic_left_shift_stage #(
            .N  (N),
            .SW (SW),
            .K  (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .src_valid (pipe[k].valid),
            .src_ovf   (pipe[k].ovf),
            .src_sign  (pipe[k].orig_sign),
            .src_shamt (pipe[k].shamt),
            .src_data  (pipe[k].data),
            .dst_valid (pipe[k+1].valid),
            .dst_ovf   (pipe[k+1].ovf),
            .dst_sign  (pipe[k+1].orig_sign),
            .dst_shamt (pipe[k+1].shamt),
            .dst_data  (pipe[k+1].data)
        );
    end

    assign bus.out_valid = pipe[SW].valid;
    assign bus.out_data  = pipe[SW].data;
    assign bus.out_ovf   = pipe[SW].ovf;

endmodule

// File: tb/tb_arithmetic_left_shift_saturating_pipelined.sv
// -----------------------------------------------------------------------------
// tb_arithmetic_left_shift_saturating_pipelined
//
// Bench for the saturating arithmetic-left-shift pipeline (N = 8). Inputs
// are driven 1 ns after the rising edge; the compare process samples on the
// falling edge. Expected results come from a plain integer model:
// value = signed(a) * 2^s, clamped to [-2^(N-1), 2^(N-1)-1].
// -----------------------------------------------------------------------------
module tb_arithmetic_left_shift_saturating_pipelined;

    localparam int N  = 8;
    localparam int SW = 3;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;
    int n_out;

    logic [N:0] exp_q[$];
    logic       held_valid;
    logic [N:0] held_word;

    arithmetic_left_shift_saturating_pipelined_if #(.N(N)) bus ();

    arithmetic_left_shift_saturating_pipelined #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model & check helpers ----------------
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [SW-1:0] s);
        longint v;
        longint hi;
        longint lo;
        v  = longint'($signed(a));
        v  = v * (longint'(1) << s);
        hi = (longint'(1) << (N - 1)) - 1;
        lo = -(longint'(1) << (N - 1));
        if (v > hi) return {1'b1, hi[N-1:0]};
        if (v < lo) return {1'b1, lo[N-1:0]};
        return {1'b0, v[N-1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
            if (held_valid) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_word", {23'd0, bus.out_ovf, bus.out_data}, {23'd0, held_word});
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'd1, 32'd0);
                end else if (bus.out_ready) begin
                    logic [N:0] e;
                    e = exp_q.pop_front();
                    n_out++;
                    check("result", {23'd0, bus.out_ovf, bus.out_data}, {23'd0, e});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data, bus.in_shamt));
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_word  = {bus.out_ovf, bus.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
    endtask

    // Send one sample into an idle pipeline and check result and latency.
    task automatic send_one(input string name, input logic [N-1:0] a,
                            input logic [SW-1:0] s, input logic [N:0] exp);
        int lat;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        bus.in_shamt  = s;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (lat > 10) break;
        end
        check({name, "_latency"}, lat, 32'd3);
        check({name, "_data"}, {24'd0, bus.out_data}, {24'd0, exp[N-1:0]});
        check({name, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, exp[N]});
    endtask

    // ---------------- directed table ----------------
    logic [N-1:0]  va [9];
    logic [SW-1:0] vs [9];
    logic [N:0]    ve [9];

    initial begin
        va[0] = 8'h05; vs[0] = 3'd3; ve[0] = 9'h028;
        va[1] = 8'h10; vs[1] = 3'd3; ve[1] = 9'h17F;
        va[2] = 8'hF0; vs[2] = 3'd3; ve[2] = 9'h080;
        va[3] = 8'hEF; vs[3] = 3'd3; ve[3] = 9'h180;
        va[4] = 8'hFF; vs[4] = 3'd7; ve[4] = 9'h080;
        va[5] = 8'h01; vs[5] = 3'd7; ve[5] = 9'h17F;
        va[6] = 8'h80; vs[6] = 3'd0; ve[6] = 9'h080;
        va[7] = 8'h80; vs[7] = 3'd1; ve[7] = 9'h180;
        va[8] = 8'h00; vs[8] = 3'd7; ve[8] = 9'h000;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [4:0]    pat;
        logic [N-1:0]  cur_data;
        logic [SW-1:0] cur_shamt;
        int            idx;
        int            cyc;
        int            out_base;

        n_checks   = 0;
        n_errors   = 0;
        n_out      = 0;
        held_valid = 1'b0;
        held_word  = '0;

        rst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Pin the model to hand-computed values.
        for (int i = 0; i < 9; i++) begin
            check($sformatf("model_pin%0d", i), {23'd0, model(va[i], vs[i])}, {23'd0, ve[i]});
        end

        // Directed vectors through the DUT.
        for (int i = 0; i < 9; i++) begin
            send_one($sformatf("vec%0d", i), va[i], vs[i], ve[i]);
        end
        idle(4);

        // Bubbles: in_valid pattern 1,0,1,1,0 appears on out_valid 3 cycles later.
        pat = 5'b01101;  // pat[0] first
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = (c < 5) ? pat[c] : 1'b0;
            bus.in_data   = 8'($urandom_range(0, 255));
            bus.in_shamt  = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (c >= 3) begin
                check($sformatf("bubble_out_valid%0d", c - 3), {31'd0, bus.out_valid},
                      {31'd0, pat[c-3]});
            end
        end
        idle(4);

        // Random stream of 20 samples with random output stalls.
        out_base  = n_out;
        idx       = 0;
        cyc       = 0;
        cur_data  = 8'($urandom_range(0, 255));
        cur_shamt = 3'($urandom_range(0, 7));
        while (idx < 20 && cyc < 1000) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'b1;
            bus.in_data   = cur_data;
            bus.in_shamt  = cur_shamt;
            @(negedge clk);
            if (bus.in_ready) begin
                idx++;
                if ($urandom_range(0, 3) == 0) begin
                    cur_data = 8'($urandom_range(0, 1) ? 8'h80 : 8'hFF);
                end else begin
                    cur_data = 8'($urandom_range(0, 255));
                end
                cur_shamt = 3'($urandom_range(0, 7));
            end
            cyc++;
        end
        check("stream_all_accepted", idx, 32'd20);
        cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_out_count", n_out - out_base, 32'd20);
        idle(3);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'h05 + 8'(i);
            bus.in_shamt  = 3'd1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("midrst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end
        send_one("post_rst", 8'h03, 3'd2, 9'h00C);
        idle(4);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arithmetic_left_shift_saturating_pipelined.md
Name: arithmetic_left_shift_saturating_pipelined

Overview:
Signed multiply by a run-time power of two (arithmetic left shift by `shamt`). The result saturates to the signed range and an overflow flag is reported.
- Complements the arithmetic right shift (signed divide by power of 2) blocks in the same arithmetic chapter.
- Built as a registered log-shifter pipeline with a valid/ready handshake.
- Sits between a producer of N-bit two's-complement samples and a consumer that can stall.

Parameters:
- N, 8, data width in bits; must be a power of two, N >= 4.
- SW, $clog2(N), shift-amount width and number of pipeline stages; derived, not overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input sample present.
- in_ready, output, 1, block accepts the input this cycle.
- in_data, input, N, signed operand.
- in_shamt, input, SW, left-shift amount, 0..N-1.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts the result this cycle.
- out_data, output, N, signed saturated result, equal to sat(in_data * 2^in_shamt).
- out_ovf, output, 1, set when saturation occurred for this result.

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid, data, shamt, ovf and sign register to 0. Therefore out_valid=0, out_data=0 and out_ovf=0. in_ready=1 once reset is released.
- Pipeline: SW register stages. Stage k (k=0..SW-1) shifts left by 2^k when shamt bit k is 1, otherwise passes data through.
- Each stage carries these fields: valid, data, remaining shamt, sticky ovf, and orig_sign (the sign of in_data).
- Latency: SW cycles from input acceptance to out_valid with no stalls. Throughput is one result per cycle.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
  - All stages load together when advance is 1 and hold when it is 0.
  - A bubble (in_valid=0 while advancing) enters as valid=0.
- Output stability: while out_valid && !out_ready, out_data and out_ovf hold stable.
- Stage overflow: shifting x left by m sets ovf if the top m+1 bits of x are not all equal. ovf is OR-ed with the incoming sticky ovf.
- Once ovf is set, data content is don't-care. The final stage outputs:
  - 0 followed by N-1 ones (max positive) if orig_sign=0;
  - 1 followed by N-1 zeros (min negative) if orig_sign=1.
- Saturation is applied combinationally inside the last stage, before its register.
- Boundary cases:
  - shamt=0 gives out_data=in_data and ovf=0.
  - Zero input never overflows.
  - -1 shifted by N-1 gives min negative with ovf=0 (exact result).
  - Most-negative input with shamt>=1 gives min negative with ovf=1.
- Simultaneous out_ready and a new in_valid in the same cycle: both transfers occur and no sample is lost or duplicated.
- Reset asserted mid-operation: all in-flight samples are dropped. No partial result appears after reset release.
- out_valid never asserts without a corresponding accepted input.
- No other arithmetic operators are used. Shifts are built from constant slices and concatenations per stage.

Decomposition:
- Shared package arith_shift_pkg:
  - function sat_max(N) and function sat_min(N) (or localparam equivalents via parameterised class-free functions);
  - packed struct typedef stage_t {valid, ovf, orig_sign, shamt, data} defined per N by the top via parameterised widths. Alternatively, keep the struct local to the top and keep only the saturation helpers in the package.
- One sub-module: arithmetic_left_shift_stage #(N, SW, K).
  - Combinational shift by 2^K with overflow detect, plus its register with async reset and enable.
  - The top instantiates it SW times in a generate-for and adds the saturation on the last stage.

Test Plan:
- N=8; in_data=0x05, shamt=3, out_ready=1 -> after 3 cycles out_data=0x28, out_ovf=0.
- in_data=0x10, shamt=3 -> out_data=0x7F, out_ovf=1. in_data=0xF0, shamt=3 -> out_data=0x80, out_ovf=0.
- in_data=0xEF, shamt=3 -> 0x80, ovf=1. in_data=0xFF, shamt=7 -> 0x80, ovf=0. in_data=0x01, shamt=7 -> 0x7F, ovf=1. in_data=0x80, shamt=0 -> 0x80, ovf=0.
- Back-to-back stream of 20 random samples with out_ready toggling randomly (~50%) -> in_ready tracks !out_valid||out_ready, outputs arrive in order, each matches the reference model sat(a*2^s), and held outputs stay stable while stalled.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid shows the same pattern delayed by 3 cycles when out_ready=1.
- Drop rst_n low with 3 samples in flight, release after 2 cycles -> out_valid=0, out_data=0, out_ovf=0 immediately (asynchronous) and no stale result after release. First new input yields a correct result after 3 cycles.
